// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmit frame sequencer: FSM state
// encodings and TX output mux select codes.
package uart_tx_pkg;

    // FSM state encodings
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP1  = 3'd4;
    localparam logic [2:0] STOP2  = 3'd5;

    // TX output mux select codes; MUX_STOP drives the idle/stop level (line high)
    localparam logic [1:0] MUX_START = 2'b00;
    localparam logic [1:0] MUX_STOP  = 2'b01;
    localparam logic [1:0] MUX_SER   = 2'b10;
    localparam logic [1:0] MUX_PAR   = 2'b11;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity of the word to transmit. Even parity makes the total
// count of ones (data + parity bit) even; odd parity makes it odd.
module uart_parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    // Reduction XOR gives even parity directly; invert it for odd parity
    assign par_bit = par_typ ? ~^data : ^data;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer. Steps the TX line through start, data
// (shifted out by the serializer), optional parity and one or two stop bits.
// Frame configuration and parity are captured when a word is accepted, so
// input changes mid-frame never disturb the frame in flight.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2_EN,
    input  logic                  ser_done,
    output logic                  ser_en,
    output logic [1:0]            mux_sel,
    output logic                  par_bit,
    output logic                  BUSY,
    output logic                  frame_done,
    output logic                  abort
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [2:0]       state;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] cnt;
    logic             par_en_q;
    logic             stop2_q;
    logic             par_q;
    logic             abort_q;
    logic             accept;
    logic             timeout;
    logic             is_final;
    logic             par_calc;

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data    (P_DATA),
        .par_typ (PAR_TYP),
        .par_bit (par_calc)
    );

    // The last stop bit of the frame is where a new word may be accepted
    assign is_final = ((state == STOP1) && !stop2_q) || (state == STOP2);

    // Next-state logic; accept marks the edge where a new word is captured
    always_comb begin
        // NOTE: every signal written here gets a default first so no path can
        // leave it unassigned and infer a latch.
        state_d = state;
        accept  = 1'b0;
        timeout = 1'b0;
        case (state)
            IDLE: begin
                if (DATA_VALID) begin
                    state_d = START;
                    accept  = 1'b1;
                end
            end
            START:  state_d = DATA;
            DATA: begin
                // ser_done takes priority over a timeout on the same cycle
                if (ser_done) begin
                    state_d = par_en_q ? PARITY : STOP1;
                end else if (cnt == CNT_LAST) begin
                    state_d = IDLE;
                    timeout = 1'b1;
                end
            end
            PARITY: state_d = STOP1;
            STOP1, STOP2: begin
                if ((state == STOP1) && stop2_q) begin
                    state_d = STOP2;
                end else if (DATA_VALID) begin
                    state_d = START;
                    accept  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!RST) state <= IDLE;
        else      state <= state_d;
    end

    // Capture frame configuration and parity when a word is accepted
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
            par_q    <= 1'b0;
        end else if (accept) begin
            par_en_q <= PAR_EN;
            stop2_q  <= STOP2_EN;
            par_q    <= par_calc;
        end
    end

    // Count DATA cycles; cleared in every other state, START always precedes DATA
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                cnt <= '0;
        else if (state == DATA)  cnt <= cnt + 1'b1;
        else                     cnt <= '0;
    end

    // One-cycle abort flag, visible in the IDLE cycle that follows a timeout
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) abort_q <= 1'b0;
        else      abort_q <= timeout;
    end

    // Output decode from state and captured registers only
    always_comb begin
        mux_sel = MUX_STOP;
        case (state)
            START:   mux_sel = MUX_START;
            DATA:    mux_sel = MUX_SER;
            PARITY:  mux_sel = MUX_PAR;
            default: mux_sel = MUX_STOP;
        endcase
    end

    assign ser_en     = (state == DATA);
    assign BUSY       = (state != IDLE);
    assign frame_done = is_final;
    assign abort      = abort_q;
    assign par_bit    = par_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed testbench for uart_tx_ctrl. Inputs are driven just after the
// falling edge and outputs are sampled on the falling edge.
module tb_uart_tx_ctrl;
    import uart_tx_pkg::*;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       STOP2_EN;
    logic       ser_done;
    logic       ser_en;
    logic [1:0] mux_sel;
    logic       par_bit;
    logic       BUSY;
    logic       frame_done;
    logic       abort;

    int tests_run;
    int tests_failed;

    // Per-frame observation record filled by run_frame
    logic [1:0] tr_mux [0:40];
    int         busy_cnt;
    int         done_cnt;
    int         done_pos;
    int         ser_cnt;
    int         abort_pos;
    logic       par_at_par;
    logic       ended;

    uart_tx_ctrl #(
        .DATA_WIDTH (8),
        .TIMEOUT    (16)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2_EN   (STOP2_EN),
        .ser_done   (ser_done),
        .ser_en     (ser_en),
        .mux_sel    (mux_sel),
        .par_bit    (par_bit),
        .BUSY       (BUSY),
        .frame_done (frame_done),
        .abort      (abort)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Request one frame and record outputs cycle by cycle until BUSY drops.
    // Cycle 1 is START; ser_done is raised in cycle 1+d (d=0: never).
    // Config and data are scrambled after acceptance to show they were captured.
    task automatic run_frame(input logic [7:0] data, input logic pe, input logic pt,
                             input logic s2, input int d);
        for (int i = 0; i <= 40; i++) tr_mux[i] = 2'bxx;
        busy_cnt   = 0;
        done_cnt   = 0;
        done_pos   = 0;
        ser_cnt    = 0;
        abort_pos  = 0;
        par_at_par = 1'bx;
        ended      = 1'b0;
        P_DATA     = data;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        STOP2_EN   = s2;
        ser_done   = 1'b0;
        DATA_VALID = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLK);
            tr_mux[c] = mux_sel;
            if (BUSY)                busy_cnt++;
            if (frame_done)          begin done_cnt++; done_pos = c; end
            if (ser_en)              ser_cnt++;
            if (abort)               abort_pos = c;
            if (mux_sel == MUX_PAR)  par_at_par = par_bit;
            DATA_VALID = 1'b0;
            P_DATA     = ~data;
            PAR_EN     = ~pe;
            PAR_TYP    = ~pt;
            STOP2_EN   = ~s2;
            ser_done   = (d > 0) && (c == 1 + d);
            if (!BUSY) begin
                ended    = 1'b1;
                ser_done = 1'b0;
                break;
            end
        end
        ser_done = 1'b0;
    endtask

    task automatic test_reset();
        RST        = 1'b0;
        P_DATA     = 8'h00;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        STOP2_EN   = 1'b0;
        ser_done   = 1'b0;
        repeat (2) @(negedge CLK);
        tests_run++;
        if ({ser_en, mux_sel, par_bit, BUSY, frame_done, abort} !== {1'b0, MUX_STOP, 4'b0000}) begin
            tests_failed++;
            $display("FAIL reset_outputs: got ser_en=%b mux=%b par=%b busy=%b done=%b abort=%b, expected 0 01 0 0 0 0",
                     ser_en, mux_sel, par_bit, BUSY, frame_done, abort);
        end
        RST = 1'b1;
        @(negedge CLK);
        tests_run++;
        if (BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: BUSY=%b expected 0", BUSY);
        end
    endtask

    task automatic test_basic_frame();
        logic [1:0] exp;
        run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 8);
        tests_run++;
        if (ended !== 1'b1) begin tests_failed++; $display("FAIL basic_end: frame did not end within 40 cycles"); end
        for (int c = 1; c <= 12; c++) begin
            exp = (c == 1) ? MUX_START : (c <= 9) ? MUX_SER : (c == 10) ? MUX_PAR : MUX_STOP;
            tests_run++;
            if (tr_mux[c] !== exp) begin
                tests_failed++;
                $display("FAIL basic_mux[%0d]: got %b expected %b", c, tr_mux[c], exp);
            end
        end
        tests_run++;
        if (busy_cnt !== 11) begin tests_failed++; $display("FAIL basic_busy: got %0d cycles expected 11", busy_cnt); end
        tests_run++;
        if (done_cnt !== 1 || done_pos !== 11) begin
            tests_failed++;
            $display("FAIL basic_done: got count %0d at cycle %0d expected 1 at 11", done_cnt, done_pos);
        end
        tests_run++;
        if (ser_cnt !== 8) begin tests_failed++; $display("FAIL basic_ser_en: got %0d expected 8", ser_cnt); end
        tests_run++;
        if (par_at_par !== 1'b0) begin tests_failed++; $display("FAIL basic_par: got %b expected 0", par_at_par); end
        tests_run++;
        if (abort_pos !== 0) begin tests_failed++; $display("FAIL basic_abort: got pulse at %0d expected none", abort_pos); end
    endtask

    task automatic test_parity_types();
        // 8'h07 has three ones: odd parity bit 0, even parity bit 1
        run_frame(8'h07, 1'b1, 1'b1, 1'b0, 8);
        tests_run++;
        if (par_at_par !== 1'b0) begin tests_failed++; $display("FAIL par_odd: got %b expected 0", par_at_par); end
        tests_run++;
        if (par_bit !== 1'b0) begin tests_failed++; $display("FAIL par_odd_hold: got %b expected 0", par_bit); end
        run_frame(8'h07, 1'b1, 1'b0, 1'b0, 8);
        tests_run++;
        if (par_at_par !== 1'b1) begin tests_failed++; $display("FAIL par_even: got %b expected 1", par_at_par); end
        @(negedge CLK);
        tests_run++;
        if (par_bit !== 1'b1) begin tests_failed++; $display("FAIL par_even_hold: got %b expected 1", par_bit); end
    endtask

    task automatic test_two_stop();
        logic [1:0] exp;
        run_frame(8'h5A, 1'b0, 1'b0, 1'b1, 8);
        for (int c = 1; c <= 12; c++) begin
            exp = (c == 1) ? MUX_START : (c <= 9) ? MUX_SER : MUX_STOP;
            tests_run++;
            if (tr_mux[c] !== exp) begin
                tests_failed++;
                $display("FAIL stop2_mux[%0d]: got %b expected %b", c, tr_mux[c], exp);
            end
        end
        tests_run++;
        if (busy_cnt !== 11) begin tests_failed++; $display("FAIL stop2_busy: got %0d expected 11", busy_cnt); end
        tests_run++;
        if (done_cnt !== 1 || done_pos !== 11) begin
            tests_failed++;
            $display("FAIL stop2_done: got count %0d at cycle %0d expected 1 at 11", done_cnt, done_pos);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_mux  [1:10] = '{MUX_START, MUX_SER, MUX_SER, MUX_STOP, MUX_START,
                                        MUX_SER, MUX_SER, MUX_PAR, MUX_STOP, MUX_STOP};
        logic       exp_busy [1:10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        logic       exp_done [1:10] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        P_DATA     = 8'h3C;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        STOP2_EN   = 1'b0;
        ser_done   = 1'b0;
        DATA_VALID = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK);
            tests_run++;
            if (mux_sel !== exp_mux[c] || BUSY !== exp_busy[c] || frame_done !== exp_done[c]) begin
                tests_failed++;
                $display("FAIL b2b[%0d]: got mux=%b busy=%b done=%b expected mux=%b busy=%b done=%b",
                         c, mux_sel, BUSY, frame_done, exp_mux[c], exp_busy[c], exp_done[c]);
            end
            if (c == 5) begin
                // second word 8'h01, even parity -> 1, captured at the back-to-back accept
                tests_run++;
                if (par_bit !== 1'b1) begin tests_failed++; $display("FAIL b2b_par: got %b expected 1", par_bit); end
            end
            DATA_VALID = (c == 4) || (c == 6);
            ser_done   = (c == 3) || (c == 7);
            if (c == 4) begin
                P_DATA  = 8'h01;
                PAR_EN  = 1'b1;
                PAR_TYP = 1'b0;
            end
        end
        DATA_VALID = 1'b0;
        ser_done   = 1'b0;
    endtask

    task automatic test_timeout();
        run_frame(8'hFF, 1'b0, 1'b0, 1'b0, 0);
        tests_run++;
        if (ended !== 1'b1) begin tests_failed++; $display("FAIL to_end: frame did not end within 40 cycles"); end
        tests_run++;
        if (ser_cnt !== 16) begin tests_failed++; $display("FAIL to_data_cycles: got %0d expected 16", ser_cnt); end
        tests_run++;
        if (abort_pos !== 18) begin tests_failed++; $display("FAIL to_abort_pos: got %0d expected 18", abort_pos); end
        tests_run++;
        if (tr_mux[18] !== MUX_STOP || done_cnt !== 0) begin
            tests_failed++;
            $display("FAIL to_idle: got mux=%b done_count=%0d expected 01 and 0", tr_mux[18], done_cnt);
        end
        @(negedge CLK);
        tests_run++;
        if (abort !== 1'b0) begin tests_failed++; $display("FAIL to_pulse_width: abort=%b expected 0", abort); end
        // ser_done on the last allowed DATA cycle wins over the timeout
        run_frame(8'h00, 1'b0, 1'b0, 1'b0, 16);
        tests_run++;
        if (abort_pos !== 0 || done_pos !== 18 || busy_cnt !== 18) begin
            tests_failed++;
            $display("FAIL to_boundary: got abort=%0d done=%0d busy=%0d expected 0 18 18",
                     abort_pos, done_pos, busy_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        P_DATA     = 8'h01;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        STOP2_EN   = 1'b0;
        ser_done   = 1'b0;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        @(negedge CLK);
        tests_run++;
        if (ser_en !== 1'b1 || par_bit !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_pre: got ser_en=%b par=%b expected 1 1", ser_en, par_bit);
        end
        #2 RST = 1'b0;
        #1;
        tests_run++;
        if ({ser_en, mux_sel, par_bit, BUSY, frame_done, abort} !== {1'b0, MUX_STOP, 4'b0000}) begin
            tests_failed++;
            $display("FAIL rst_mid: got ser_en=%b mux=%b par=%b busy=%b done=%b abort=%b, expected 0 01 0 0 0 0",
                     ser_en, mux_sel, par_bit, BUSY, frame_done, abort);
        end
        @(negedge CLK);
        RST = 1'b1;
        run_frame(8'h01, 1'b1, 1'b0, 1'b0, 8);
        tests_run++;
        if (tr_mux[1] !== MUX_START || busy_cnt !== 11 || done_pos !== 11 || par_at_par !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_clean_frame: got mux1=%b busy=%0d done=%0d par=%b expected 00 11 11 1",
                     tr_mux[1], busy_cnt, done_pos, par_at_par);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic_frame();
        test_parity_types();
        test_two_stop();
        test_back_to_back();
        test_timeout();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
